// File: rtl/palette_ram_fade.sv
// Multi-bank runtime-writable colour palette with a 2-stage lookup pipeline
// and a global brightness fade engine that scales every channel by level/16.
module palette_ram_fade #(
  parameter int INDEX_W  = 4,
  parameter int BANK_W   = 2,
  parameter int COLOR_W  = 4,
  parameter int FADE_DIV = 1024
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   rd_valid_i,
  input  logic [BANK_W-1:0]      rd_bank_i,
  input  logic [INDEX_W-1:0]     rd_index_i,
  output logic                   out_valid_o,
  output logic [COLOR_W-1:0]     red_o,
  output logic [COLOR_W-1:0]     green_o,
  output logic [COLOR_W-1:0]     blue_o,
  input  logic                   wr_en_i,
  input  logic [BANK_W-1:0]      wr_bank_i,
  input  logic [INDEX_W-1:0]     wr_index_i,
  input  logic [3*COLOR_W-1:0]   wr_data_i,
  output logic                   wr_ready_o,
  input  logic                   fade_start_i,
  input  logic                   fade_dir_i,
  output logic                   fade_busy_o,
  output logic                   fade_done_o,
  output logic [4:0]             brightness_o
);

  localparam int ADDR_W  = BANK_W + INDEX_W;
  localparam int DEPTH   = 1 << ADDR_W;
  localparam int WORD_W  = 3 * COLOR_W;
  localparam int PRESC_W = $clog2(FADE_DIV);

  localparam logic [ADDR_W-1:0]  ADDR_LAST   = '1;
  localparam logic [PRESC_W-1:0] PRESC_LAST  = PRESC_W'(FADE_DIV - 1);
  localparam logic [4:0]         BRIGHT_FULL = 5'd16;

  typedef enum logic {INIT, READY} init_state_t;
  typedef enum logic {FADE_IDLE, FADE_RAMP} fade_state_t;

  init_state_t init_state_q, init_state_d;
  logic [ADDR_W-1:0] init_addr_q, init_addr_d;

  fade_state_t fade_state_q, fade_state_d;
  logic [4:0]  target_q, target_d;
  logic [4:0]  bright_q, bright_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic        done_q, done_d;

  logic [WORD_W-1:0] mem [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [WORD_W-1:0] mem_wdata;

  logic              s1_valid_q;
  logic [WORD_W-1:0] s1_word_q;
  logic              s2_valid_q;
  logic [WORD_W-1:0] rgb_d, rgb_q;

  function automatic logic [COLOR_W-1:0] scale(input logic [COLOR_W-1:0] c,
                                               input logic [4:0] b);
    logic [COLOR_W+4:0] prod;
    prod = (COLOR_W+5)'(c) * (COLOR_W+5)'(b);
    return COLOR_W'(prod >> 4);
  endfunction

  // Init sweep owns the single write port until every entry has been cleared.
  always_comb begin
    init_state_d = init_state_q;
    init_addr_d  = init_addr_q;
    mem_we       = 1'b0;
    mem_waddr    = {wr_bank_i, wr_index_i};
    mem_wdata    = wr_data_i;
    case (init_state_q)
      INIT: begin
        mem_we      = 1'b1;
        mem_waddr   = init_addr_q;
        mem_wdata   = '0;
        init_addr_d = init_addr_q + 1'b1;
        if (init_addr_q == ADDR_LAST) init_state_d = READY;
      end
      READY:   mem_we = wr_en_i;
      default: init_state_d = INIT;
    endcase
  end

  always_comb begin
    fade_state_d = fade_state_q;
    target_d     = target_q;
    presc_d      = presc_q;
    bright_d     = bright_q;
    done_d       = 1'b0;
    case (fade_state_q)
      FADE_IDLE: begin
        if (fade_start_i) begin
          target_d     = fade_dir_i ? BRIGHT_FULL : 5'd0;
          presc_d      = '0;
          fade_state_d = FADE_RAMP;
        end
      end
      FADE_RAMP: begin
        if (bright_q == target_q) begin
          done_d       = 1'b1;
          fade_state_d = FADE_IDLE;
        end else if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          if (target_q > bright_q) begin
            if (bright_q != BRIGHT_FULL) bright_d = bright_q + 5'd1;
          end else if (bright_q != 5'd0) begin
            bright_d = bright_q - 5'd1;
          end
          if (bright_d == target_q) begin
            done_d       = 1'b1;
            fade_state_d = FADE_IDLE;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      default: fade_state_d = FADE_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      init_state_q <= INIT;
      init_addr_q  <= '0;
      fade_state_q <= FADE_IDLE;
      target_q     <= BRIGHT_FULL;
      bright_q     <= BRIGHT_FULL;
      presc_q      <= '0;
      done_q       <= 1'b0;
    end else begin
      init_state_q <= init_state_d;
      init_addr_q  <= init_addr_d;
      fade_state_q <= fade_state_d;
      target_q     <= target_d;
      bright_q     <= bright_d;
      presc_q      <= presc_d;
      done_q       <= done_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Registered read returns the pre-write word on a same-address collision.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_valid_q <= 1'b0;
      s1_word_q  <= '0;
    end else begin
      s1_valid_q <= rd_valid_i;
      s1_word_q  <= mem[{rd_bank_i, rd_index_i}];
    end
  end

  // Scaling uses the level taking effect at this edge, so a step applies immediately.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
      assign rgb_d[(2-gi)*COLOR_W +: COLOR_W] =
        (init_state_q == INIT) ? '0 : scale(s1_word_q[(2-gi)*COLOR_W +: COLOR_W], bright_d);
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s2_valid_q <= 1'b0;
      rgb_q      <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      rgb_q      <= rgb_d;
    end
  end

  assign out_valid_o  = s2_valid_q;
  assign red_o        = rgb_q[2*COLOR_W +: COLOR_W];
  assign green_o      = rgb_q[COLOR_W +: COLOR_W];
  assign blue_o       = rgb_q[0 +: COLOR_W];
  assign wr_ready_o   = (init_state_q == READY);
  assign fade_busy_o  = (fade_state_q == FADE_RAMP);
  assign fade_done_o  = done_q;
  assign brightness_o = bright_q;

endmodule

// File: tb/tb_palette_ram_fade.sv
// Directed bench for palette_ram_fade: init sweep, writes, lookups, fade ramps, reset.
module tb_palette_ram_fade;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rd_valid = 1'b0;
  logic [1:0]  rd_bank = '0;
  logic [3:0]  rd_index = '0;
  logic        out_valid;
  logic [3:0]  red, green, blue;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_bank = '0;
  logic [3:0]  wr_index = '0;
  logic [11:0] wr_data = '0;
  logic        wr_ready;
  logic        fade_start = 1'b0;
  logic        fade_dir = 1'b0;
  logic        fade_busy;
  logic        fade_done;
  logic [4:0]  brightness;

  int errors = 0;
  int checks = 0;

  palette_ram_fade #(
    .INDEX_W(4), .BANK_W(2), .COLOR_W(4), .FADE_DIV(4)
  ) dut (
    .clk_i(clk), .reset_i(reset),
    .rd_valid_i(rd_valid), .rd_bank_i(rd_bank), .rd_index_i(rd_index),
    .out_valid_o(out_valid), .red_o(red), .green_o(green), .blue_o(blue),
    .wr_en_i(wr_en), .wr_bank_i(wr_bank), .wr_index_i(wr_index), .wr_data_i(wr_data),
    .wr_ready_o(wr_ready),
    .fade_start_i(fade_start), .fade_dir_i(fade_dir),
    .fade_busy_o(fade_busy), .fade_done_o(fade_done), .brightness_o(brightness)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset;
    reset = 1'b1; rd_valid = 1'b0; wr_en = 1'b0; fade_start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_ready(output int cycles);
    cycles = 0;
    while (wr_ready !== 1'b1 && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic write_entry(input logic [1:0] b, input logic [3:0] i, input logic [11:0] d);
    wr_en = 1'b1; wr_bank = b; wr_index = i; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic lookup(input logic [1:0] b, input logic [3:0] i,
                        output logic early_v, output logic v, output logic [11:0] rgb);
    rd_valid = 1'b1; rd_bank = b; rd_index = i;
    @(negedge clk);
    rd_valid = 1'b0;
    early_v = out_valid;
    @(negedge clk);
    v = out_valid;
    rgb = {red, green, blue};
  endtask

  task automatic test_reset;
    int n;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    checks++; if ({red, green, blue} !== 12'h000) begin errors++; $display("FAIL reset_rgb: got %03h expected 000", {red, green, blue}); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready: got %0b expected 0", wr_ready); end
    checks++; if (fade_busy !== 1'b0 || fade_done !== 1'b0) begin errors++; $display("FAIL reset_fade_flags: got busy=%0b done=%0b expected 0/0", fade_busy, fade_done); end
    checks++; if (brightness !== 5'd16) begin errors++; $display("FAIL reset_brightness: got %0d expected 16", brightness); end
    reset = 1'b0;
    wait_ready(n);
    checks++; if (n !== 64) begin errors++; $display("FAIL init_length: got %0d cycles expected 64", n); end
    $display("test_reset: init took %0d cycles", n);
  endtask

  task automatic test_init_write_drop;
    int n;
    logic ev, v;
    logic [11:0] rgb;
    apply_reset();
    repeat (10) @(negedge clk);
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL init_wr_ready_low: got %0b expected 0", wr_ready); end
    write_entry(2'd0, 4'd2, 12'hF73);
    wait_ready(n);
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL init_wait_ready: got %0b expected 1", wr_ready); end
    lookup(2'd0, 4'd2, ev, v, rgb);
    checks++; if (v !== 1'b1 || rgb !== 12'h000) begin errors++; $display("FAIL init_write_dropped: got v=%0b rgb=%03h expected v=1 rgb=000", v, rgb); end
    $display("test_init_write_drop: entry {0,2} reads %03h", rgb);
  endtask

  task automatic test_write_lookup;
    logic ev, v;
    logic [11:0] rgb;
    write_entry(2'd1, 4'd5, 12'hF73);
    lookup(2'd1, 4'd5, ev, v, rgb);
    checks++; if (ev !== 1'b0) begin errors++; $display("FAIL latency_early_valid: got %0b expected 0", ev); end
    checks++; if (v !== 1'b1) begin errors++; $display("FAIL lookup_valid: got %0b expected 1", v); end
    checks++; if (rgb !== 12'hF73) begin errors++; $display("FAIL lookup_1_5: got %03h expected F73", rgb); end
    $display("test_write_lookup: {1,5} -> %03h", rgb);
    lookup(2'd0, 4'd5, ev, v, rgb);
    checks++; if (v !== 1'b1 || rgb !== 12'h000) begin errors++; $display("FAIL lookup_0_5: got v=%0b rgb=%03h expected v=1 rgb=000", v, rgb); end
    $display("test_write_lookup: {0,5} -> %03h", rgb);
  endtask

  task automatic test_read_during_write;
    write_entry(2'd2, 4'd9, 12'h5A6);
    wr_en = 1'b1; wr_bank = 2'd2; wr_index = 4'd9; wr_data = 12'h1C4;
    rd_valid = 1'b1; rd_bank = 2'd2; rd_index = 4'd9;
    @(negedge clk);
    wr_en = 1'b0;
    @(negedge clk);
    rd_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || {red, green, blue} !== 12'h5A6) begin errors++; $display("FAIL rdw_old: got v=%0b rgb=%03h expected v=1 rgb=5A6", out_valid, {red, green, blue}); end
    $display("test_read_during_write: same-cycle read %03h", {red, green, blue});
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || {red, green, blue} !== 12'h1C4) begin errors++; $display("FAIL rdw_new: got v=%0b rgb=%03h expected v=1 rgb=1C4", out_valid, {red, green, blue}); end
    $display("test_read_during_write: next-cycle read %03h", {red, green, blue});
  endtask

  task automatic test_back_to_back;
    logic [11:0] exp_mem [64];
    logic [5:0]  a;
    for (int i = 0; i < 64; i++) begin
      a = 6'(i);
      exp_mem[i] = 12'(i * 12'h0A7 + 12'h135);
      write_entry(a[5:4], a[3:0], exp_mem[i]);
    end
    for (int k = 0; k < 67; k++) begin
      if (k >= 2 && k < 66) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %0b expected 1", k - 2, out_valid); end
        checks++; if ({red, green, blue} !== exp_mem[k-2]) begin errors++; $display("FAIL b2b_data[%0d]: got %03h expected %03h", k - 2, {red, green, blue}, exp_mem[k-2]); end
        $display("test_back_to_back: entry %0d -> %03h", k - 2, {red, green, blue});
      end else begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle_valid[%0d]: got %0b expected 0", k, out_valid); end
      end
      if (k < 64) begin
        a = 6'(k);
        rd_valid = 1'b1; rd_bank = a[5:4]; rd_index = a[3:0];
      end else begin
        rd_valid = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_fade_down;
    int done_pulses = 0;
    write_entry(2'd1, 4'd5, 12'hF73);
    fade_start = 1'b1; fade_dir = 1'b0;
    for (int cyc = 1; cyc <= 72; cyc++) begin
      @(negedge clk);
      if (fade_done === 1'b1) done_pulses++;
      case (cyc)
        1: begin
          fade_start = 1'b0;
          checks++; if (fade_busy !== 1'b1 || brightness !== 5'd16) begin errors++; $display("FAIL fade_start: got busy=%0b bright=%0d expected 1/16", fade_busy, brightness); end
        end
        4:  begin checks++; if (brightness !== 5'd16) begin errors++; $display("FAIL fade_pre_step: got %0d expected 16", brightness); end end
        5:  begin checks++; if (brightness !== 5'd15) begin errors++; $display("FAIL fade_first_step: got %0d expected 15", brightness); end end
        20: begin fade_start = 1'b1; fade_dir = 1'b1; end
        21: begin fade_start = 1'b0; fade_dir = 1'b0; end
        25: begin checks++; if (brightness !== 5'd10) begin errors++; $display("FAIL fade_ignore_start: got %0d expected 10", brightness); end end
        33: begin
          checks++; if (brightness !== 5'd8) begin errors++; $display("FAIL fade_half: got %0d expected 8", brightness); end
          rd_valid = 1'b1; rd_bank = 2'd1; rd_index = 4'd5;
        end
        34: rd_valid = 1'b0;
        35: begin
          checks++; if (out_valid !== 1'b1 || {red, green, blue} !== 12'h731) begin errors++; $display("FAIL fade_rgb_half: got v=%0b rgb=%03h expected v=1 rgb=731", out_valid, {red, green, blue}); end
          $display("test_fade_down: brightness 8 -> %03h", {red, green, blue});
        end
        64: begin checks++; if (brightness !== 5'd1 || fade_done !== 1'b0 || fade_busy !== 1'b1) begin errors++; $display("FAIL fade_last_before: got bright=%0d done=%0b busy=%0b expected 1/0/1", brightness, fade_done, fade_busy); end end
        65: begin checks++; if (brightness !== 5'd0 || fade_done !== 1'b1 || fade_busy !== 1'b0) begin errors++; $display("FAIL fade_end: got bright=%0d done=%0b busy=%0b expected 0/1/0", brightness, fade_done, fade_busy); end end
        66: begin rd_valid = 1'b1; rd_bank = 2'd1; rd_index = 4'd5; end
        67: rd_valid = 1'b0;
        68: begin
          checks++; if (out_valid !== 1'b1 || {red, green, blue} !== 12'h000) begin errors++; $display("FAIL fade_rgb_black: got v=%0b rgb=%03h expected v=1 rgb=000", out_valid, {red, green, blue}); end
          $display("test_fade_down: brightness 0 -> %03h", {red, green, blue});
        end
        default: ;
      endcase
    end
    checks++; if (done_pulses !== 1) begin errors++; $display("FAIL fade_done_count: got %0d expected 1", done_pulses); end
    checks++; if (brightness !== 5'd0) begin errors++; $display("FAIL fade_saturate: got %0d expected 0", brightness); end
    $display("test_fade_down: done pulses %0d, final brightness %0d", done_pulses, brightness);
  endtask

  task automatic test_fade_at_target;
    fade_start = 1'b1; fade_dir = 1'b0;
    @(negedge clk);
    fade_start = 1'b0;
    checks++; if (fade_busy !== 1'b1 || fade_done !== 1'b0 || brightness !== 5'd0) begin errors++; $display("FAIL at_target_busy: got busy=%0b done=%0b bright=%0d expected 1/0/0", fade_busy, fade_done, brightness); end
    @(negedge clk);
    checks++; if (fade_busy !== 1'b0 || fade_done !== 1'b1 || brightness !== 5'd0) begin errors++; $display("FAIL at_target_done: got busy=%0b done=%0b bright=%0d expected 0/1/0", fade_busy, fade_done, brightness); end
    @(negedge clk);
    checks++; if (fade_done !== 1'b0) begin errors++; $display("FAIL at_target_pulse: got %0b expected 0", fade_done); end
    $display("test_fade_at_target: brightness %0d", brightness);
  endtask

  task automatic test_reset_mid_fade;
    int n;
    logic ev, v;
    logic [11:0] rgb;
    fade_start = 1'b1; fade_dir = 1'b1;
    @(negedge clk);
    fade_start = 1'b0;
    repeat (9) @(negedge clk);
    checks++; if (brightness !== 5'd2 || fade_busy !== 1'b1) begin errors++; $display("FAIL fade_up_partial: got bright=%0d busy=%0b expected 2/1", brightness, fade_busy); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (brightness !== 5'd16 || fade_busy !== 1'b0 || wr_ready !== 1'b0) begin errors++; $display("FAIL reset_mid_fade: got bright=%0d busy=%0b ready=%0b expected 16/0/0", brightness, fade_busy, wr_ready); end
    checks++; if (out_valid !== 1'b0 || fade_done !== 1'b0) begin errors++; $display("FAIL reset_mid_flush: got v=%0b done=%0b expected 0/0", out_valid, fade_done); end
    reset = 1'b0;
    wait_ready(n);
    checks++; if (n !== 64) begin errors++; $display("FAIL reinit_length: got %0d expected 64", n); end
    lookup(2'd1, 4'd5, ev, v, rgb);
    checks++; if (v !== 1'b1 || rgb !== 12'h000) begin errors++; $display("FAIL reinit_cleared: got v=%0b rgb=%03h expected v=1 rgb=000", v, rgb); end
    $display("test_reset_mid_fade: reinit %0d cycles, {1,5} -> %03h", n, rgb);
  endtask

  initial begin
    test_reset();
    test_init_write_drop();
    test_write_lookup();
    test_read_during_write();
    test_back_to_back();
    test_fade_down();
    test_fade_at_target();
    test_reset_mid_fade();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/palette_ram_fade.md
# palette_ram_fade

Runtime-writable, multi-bank colour palette with a pipelined lookup path and a global brightness fade engine. It sits between the sprite/background index generators and the VGA colour output. It converts a per-pixel colour index plus a bank select into 12-bit (default) RGB, scaled by a brightness level that a fade FSM can ramp for screen transitions. Palette contents are written at run time by the game logic instead of being fixed constants.

## Interface
- INDEX_W, 4, colour index width; entries per bank = 2^INDEX_W
- BANK_W, 2, bank-select width; banks = 2^BANK_W
- COLOR_W, 4, width of each of red/green/blue
- FADE_DIV, 1024, clock cycles per brightness step (≥2)

- Clk  in  1  system clock; the only clock
- Reset  in  1  synchronous, active-high reset
- rd_valid  in  1  lookup request this cycle
- rd_bank  in  BANK_W  bank for lookup
- rd_index  in  INDEX_W  colour index for lookup
- out_valid  out  1  red/green/blue valid (rd_valid delayed 2)
- red, green, blue  out  COLOR_W each  scaled colour
- wr_en  in  1  palette write strobe
- wr_bank  in  BANK_W  write bank
- wr_index  in  INDEX_W  write entry
- wr_data  in  3*COLOR_W  {red, green, blue}, red in MSBs
- wr_ready  out  1  high when writes are accepted
- fade_start  in  1  begin ramp (sampled in FADE_IDLE only)
- fade_dir  in  1  1 = ramp to full brightness, 0 = ramp to black
- fade_busy  out  1  ramp in progress
- fade_done  out  1  one-cycle pulse when the ramp reaches its target
- brightness  out  5  current level, 0..16

## Operation
- Storage: 2^(BANK_W+INDEX_W) entries of 3*COLOR_W bits. Address = {bank, index}.
- Init FSM: INIT → READY.
  - Reset enters INIT with address counter 0.
  - INIT writes zero to one entry per cycle and then increments the counter.
  - After the last entry, the FSM goes to READY. INIT lasts exactly 2^(BANK_W+INDEX_W) cycles.
  - wr_ready = 0 in INIT and 1 in READY. A wr_en while wr_ready = 0 is dropped with no retry.
- Write: when wr_en && wr_ready, the entry updates at the clock edge.
- Lookup pipeline:
  - Stage 1 registers the RAM word and valid.
  - Stage 2 scales each channel and registers the outputs and out_valid.
  - The pipeline runs every cycle and does not stall.
  - While INIT is active at stage 2, red/green/blue are forced to 0. out_valid still follows rd_valid.
- Scaling per channel: out = (c × brightness) >> 4.
  - Uses a COLOR_W+5-bit intermediate product.
  - brightness 16 is identity; brightness 0 gives black. Truncation only, no rounding.
- Fade FSM: FADE_IDLE, FADE_RAMP.
  - In FADE_IDLE, fade_start latches the target (16 if fade_dir, else 0), clears the prescaler, and enters FADE_RAMP.
  - In FADE_RAMP, the prescaler counts 0..FADE_DIV-1. On the wrap, brightness steps ±1 toward the target.
  - When brightness equals the target after a step, fade_done pulses for one cycle and the FSM returns to FADE_IDLE.
  - If brightness already equals the target at start, the FSM stays in FADE_RAMP for one cycle, pulses fade_done, then returns to FADE_IDLE without changing brightness.
  - fade_start during FADE_RAMP is ignored. fade_busy = (state == FADE_RAMP).
- Brightness saturates at 0 and 16; it never wraps.

## Timing
- Reset values:
  - out_valid 0; red, green, blue 0; wr_ready 0.
  - fade_busy 0; fade_done 0; brightness 16.
  - Init state INIT; fade state FADE_IDLE; both pipeline stages cleared.
- Lookup latency is 2 cycles: a request at edge N gives out_valid and data after edge N+2. Throughput is 1 per cycle.
- Read-during-write to the same address returns the old data. The new value is visible to a lookup issued the cycle after the write.
- A brightness change affects samples entering stage 2 on or after the edge that updates brightness.
- Fade ramp length is |target − start| × FADE_DIV cycles. fade_done is asserted in the cycle after the final step edge.
- Reset mid-operation:
  - Aborts the fade, with brightness back to 16.
  - Flushes the pipeline.
  - Restarts INIT, so all entries are re-cleared.
- wr_ready rises the cycle after the last INIT write.

## Test plan
- Reset, then count cycles to wr_ready = 1 → exactly 64 cycles with default parameters. A lookup of any entry afterwards returns 0,0,0.
- Write bank 1 index 5 = 12'hF73, then look up {1,5} → out_valid and red=F, green=7, blue=3 appear 2 cycles later. Lookup {0,5} → 0,0,0.
- Issue a write and a lookup of the same address in the same cycle → the lookup returns the old value. A lookup on the next cycle returns the new value.
- Stream 64 back-to-back lookups → 64 consecutive out_valid cycles in request order with no gaps.
- Use FADE_DIV=4 and entry F73, then fade_dir=0 with fade_start:
  - brightness goes 16→0 over 64 cycles, with fade_done pulsing once.
  - At brightness 8 the output is 7,3,1; at 0 it is 0,0,0.
  - fade_start during the ramp has no effect.
- Assert wr_en during INIT → the write is dropped and the entry reads 0. Reset mid-fade → brightness 16, fade_busy 0, wr_ready 0 on the next cycle.
